mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (fetch) and the MEM stage (load/store).
//  Sits between stage_IF/stage_MEM and the memory macro, one transaction in flight at a time.
//  Data requests have priority; a bounded-streak rule prevents fetch starvation.
//  Flushes on taken jump/branch and stops issuing fetches on halt.
// PARAMETERS
//  MEM_ADDR_WIDTH  `MEM_ADDR_WIDTH  memory address width
//  WORD_WIDTH      `WORD_WIDTH      data word width
//  MEM_LATENCY     2                cycles from mem_en to valid mem_rdata; legal range 1..15
//  MAX_STREAK      4                max consecutive data grants while a fetch waits; legal range >=1
// PORTS
//  clk          in   1    clock
//  rst          in   1    asynchronous reset, active-high
//  halt         in   1    core halted: no new fetch grants
//  flush        in   1    taken jump/branch: drop the in-flight fetch response
//  if_req       in   1    fetch request, held until if_gnt
//  if_addr      in   MAW  fetch address
//  if_gnt       out  1    fetch accepted this cycle
//  if_rvalid    out  1    1-cycle pulse: if_rdata valid
//  if_rdata     out  WW   fetched instruction
//  d_req        in   1    data request, held until d_gnt
//  d_we         in   1    1 = store, 0 = load
//  d_addr       in   MAW  data address
//  d_wdata      in   WW   store data
//  d_byt_typ    in   3    byte/half/word type, passed through to memory
//  d_gnt        out  1    data accepted this cycle
//  d_rvalid     out  1    1-cycle pulse: load data valid or store complete
//  d_rdata      out  WW   load data; 0 for stores
//  mem_en       out  1    memory access strobe, 1 cycle
//  mem_we       out  1    memory write enable
//  mem_addr     out  MAW  memory address
//  mem_wdata    out  WW   memory write data
//  mem_byt_typ  out  3    memory byte type
//  mem_rdata    in   WW   memory read data
// BEHAVIOUR
//  Reset: state=IDLE, streak=0, drop=0, cnt=0. All outputs are 0 while rst is high.
//  Reset mid-transaction abandons the transaction; no rvalid is ever issued for it.
//  FSM IDLE -> WAIT -> RESP.
//  IDLE: grant is combinational in cycle T. At most one of if_gnt/d_gnt is high.
//   - Winner is data if d_req and !(if_req && !halt && streak==MAX_STREAK).
//   - Otherwise winner is fetch if if_req && !halt.
//   - On a grant: mem_en=1, mem_* driven from the winner (mem_we=0 for fetch), owner latched, cnt=MEM_LATENCY-1, go to WAIT.
//  WAIT: mem_en=0. Decrement cnt. When cnt==0, register mem_rdata and go to RESP.
//  RESP (cycle T+MEM_LATENCY+1): owner rvalid=1 for exactly one cycle with registered rdata.
//   - Fetch rvalid is suppressed if drop is set.
//   - RESP behaves as IDLE for arbitration, so the next grant may occur in the same cycle.
//   - Sustained throughput: one access per MEM_LATENCY+1 cycles.
//  streak:
//   - +1 (saturating at MAX_STREAK) on a data grant while if_req && !halt.
//   - Cleared on a fetch grant, or in any IDLE/RESP cycle where !if_req || halt.
//  drop:
//   - Set by flush in any cycle from the fetch grant cycle through the last WAIT cycle.
//   - Cleared on the next grant.
//   - Flush in IDLE, in RESP, or during a data transaction has no effect.
//   - Flush in the grant cycle still lets the grant happen; its response is then dropped.
//  d_rdata=0 and mem_rdata is ignored for stores.
//  halt never blocks data requests. A fetch already in flight when halt rises still completes.
//  rdata outputs hold their value between pulses; rvalid is the only qualifier.
// STRUCTURE
//  constants.vh gains `ARB_IDLE/`ARB_WAIT/`ARB_RESP (2-bit), `OWN_IF/`OWN_D (1-bit) and `MEM_LATENCY.
//  It reuses `MEM_ADDR_WIDTH and `WORD_WIDTH.
//  One sub-module, mem_arb_pick: combinational winner select from d_req, if_req, halt and streak_full.
//  FSM, counters and response registers live in this module.
// TESTING
//  Lone fetch if_req at T, MEM_LATENCY=2 -> if_gnt@T, mem_en@T, if_rvalid@T+3 with if_rdata=mem_rdata@T+2.
//  if_req and d_req simultaneous from IDLE -> d_gnt first; if_gnt at the RESP cycle of the data access.
//  d_req held high and if_req held high, MAX_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F...
//  Fetch granted, flush 1 cycle later -> no if_rvalid; next fetch's if_rvalid is delivered normally.
//  halt=1 with if_req and a store d_req (d_wdata=32'hDEADBEEF) -> only d_gnt; mem_we=1; d_rvalid with d_rdata=0; if_gnt never asserted.
//  rst pulsed in WAIT -> all outputs 0 immediately; no rvalid afterwards; next request served from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM state and owner encodings for the memory port arbiter.
//   MEM_ADDR_WIDTH / WORD_WIDTH : memory address and data word widths
//   arb_state_t                 : ARB_IDLE / ARB_WAIT / ARB_RESP
//   owner_t                     : OWN_IF (fetch) / OWN_D (load/store)
package mem_port_arbiter_pkg;
    localparam int MEM_ADDR_WIDTH = 16;
    localparam int WORD_WIDTH = 32;
    typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_WAIT = 2'd1, ARB_RESP = 2'd2} arb_state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of core-side (fetch/data), control and memory-side signals.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants, responses and mem_*)
//   master : core/memory view (the opposite directions)
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;
    logic                      halt;
    logic                      flush;
    logic                      if_req;
    logic [MEM_ADDR_WIDTH-1:0] if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [WORD_WIDTH-1:0]     if_rdata;
    logic                      d_req;
    logic                      d_we;
    logic [MEM_ADDR_WIDTH-1:0] d_addr;
    logic [WORD_WIDTH-1:0]     d_wdata;
    logic [2:0]                d_byt_typ;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [WORD_WIDTH-1:0]     d_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0]     mem_wdata;
    logic [2:0]                mem_byt_typ;
    logic [WORD_WIDTH-1:0]     mem_rdata;
    modport slave (
        input  halt, flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_byt_typ, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_byt_typ
    );
    modport master (
        output halt, flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_byt_typ, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_byt_typ
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between data and fetch requests.
//   in  d_req, if_req, halt, streak_full
//   out pick_d (data wins), pick_f (fetch wins); never both high
module mem_arb_pick (
    input  logic d_req,
    input  logic if_req,
    input  logic halt,
    input  logic streak_full,
    output logic pick_d,
    output logic pick_f
);
    always_comb begin
        pick_d = d_req && !(if_req && !halt && streak_full);
        pick_f = !pick_d && if_req && !halt;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and load/store, one access in flight.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (halt/flush, fetch port, data port, memory port)
//   MEM_LATENCY (1..15) cycles from mem_en to valid mem_rdata; MAX_STREAK (>=1) data grants while fetch waits
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_STREAK = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    arb_state_t state, state_n;
    owner_t owner;
    logic we_q;
    logic [3:0] cnt;
    logic [SW-1:0] streak;
    logic drop;
    logic [WORD_WIDTH-1:0] if_rdata_q, d_rdata_q;
    logic pick_d, pick_f, arb, grant_d, grant_f, grant, last_wait, f_pend;

    mem_arb_pick u_pick (
        .d_req(bus.d_req),
        .if_req(bus.if_req),
        .halt(bus.halt),
        .streak_full(streak == SW'(MAX_STREAK)),
        .pick_d(pick_d),
        .pick_f(pick_f)
    );

    // RESP arbitrates exactly like IDLE so back-to-back accesses lose no cycle
    assign arb = state != ARB_WAIT;
    // grants are gated by rst so every output is 0 while reset is held
    assign grant_d = !rst && arb && pick_d;
    assign grant_f = !rst && arb && pick_f;
    assign grant = grant_d || grant_f;
    assign last_wait = state == ARB_WAIT && cnt == 4'd0;
    assign f_pend = bus.if_req && !bus.halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else state <= state_n;
    end

    always_comb state_n = arb ? (grant ? ARB_WAIT : ARB_IDLE) : (cnt == 4'd0 ? ARB_RESP : ARB_WAIT);

    always_comb begin
        bus.if_gnt = grant_f;
        bus.d_gnt = grant_d;
        bus.mem_en = grant;
        bus.mem_we = grant_d && bus.d_we;
        bus.mem_addr = grant_d ? bus.d_addr : grant_f ? bus.if_addr : '0;
        bus.mem_wdata = grant_d ? bus.d_wdata : '0;
        bus.mem_byt_typ = grant_d ? bus.d_byt_typ : '0;
        bus.if_rvalid = state == ARB_RESP && owner == OWN_IF && !drop;
        bus.d_rvalid = state == ARB_RESP && owner == OWN_D;
        bus.if_rdata = if_rdata_q;
        bus.d_rdata = d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_IF;
            we_q <= 1'b0;
            cnt <= 4'd0;
            streak <= '0;
            drop <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner <= grant_d ? OWN_D : OWN_IF;
                we_q <= grant_d && bus.d_we;
                cnt <= 4'(MEM_LATENCY - 1);
            end else if (state == ARB_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (arb)
                streak <= (grant_f || !f_pend) ? '0 :
                          (grant_d && streak != SW'(MAX_STREAK)) ? streak + 1'b1 : streak;
            // a flush anywhere from the fetch grant through its last wait cycle kills that response
            drop <= grant_f ? bus.flush :
                    grant_d ? 1'b0 :
                    (state == ARB_WAIT && owner == OWN_IF && bus.flush) ? 1'b1 : drop;
            // a dropped fetch leaves if_rdata untouched so it holds the last delivered word
            if (last_wait && owner == OWN_IF && !(drop || bus.flush)) if_rdata_q <= bus.mem_rdata;
            if (last_wait && owner == OWN_D) d_rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench with a behavioural memory and a response scoreboard.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LATENCY(L), .MAX_STREAK(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WORD_WIDTH-1:0] mem_val(input logic [MEM_ADDR_WIDTH-1:0] a);
        return {a ^ 16'hC3C3, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory returns mem_val(addr) exactly L cycles after mem_en, for loads and stores alike
    logic [MEM_ADDR_WIDTH-1:0] pipe_a [L];
    bit pipe_v [L];
    always @(posedge clk) begin
        pipe_v[0] <= bus.mem_en;
        pipe_a[0] <= bus.mem_addr;
        for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign bus.mem_rdata = pipe_v[L-1] ? mem_val(pipe_a[L-1]) : 32'h0BAD_0BAD;

    typedef struct {bit is_f; bit dropped; logic [WORD_WIDTH-1:0] data; int due;} exp_t;
    typedef struct {bit is_f; int c;} gnt_t;
    exp_t sb[$];
    gnt_t glog[$];

    always @(negedge clk) begin : mon
        exp_t e;
        gnt_t g;
        if (rst) sb.delete();
        else begin
            if (sb.size() > 0 && sb[0].is_f && bus.flush && cyc < sb[0].due) begin
                e = sb[0];
                e.dropped = 1'b1;
                sb[0] = e;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("if_rvalid", bus.if_rvalid, e.is_f && !e.dropped);
                chk("d_rvalid", bus.d_rvalid, !e.is_f);
                if (e.is_f && !e.dropped) chk("if_rdata", bus.if_rdata, e.data);
                if (!e.is_f) chk("d_rdata", bus.d_rdata, e.data);
            end else begin
                chk("stray_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
            end
            chk("one_gnt", bus.if_gnt && bus.d_gnt, 0);
            if (bus.if_gnt || bus.d_gnt) begin
                e.is_f = bus.if_gnt;
                e.dropped = bus.if_gnt && bus.flush;
                e.data = bus.if_gnt ? mem_val(bus.if_addr) : bus.d_we ? '0 : mem_val(bus.d_addr);
                e.due = cyc + L + 1;
                sb.push_back(e);
                chk("mem_addr", bus.mem_addr, bus.if_gnt ? bus.if_addr : bus.d_addr);
                chk("mem_we", bus.mem_we, bus.d_gnt && bus.d_we);
                chk("mem_en", bus.mem_en, 1);
                if (bus.d_gnt && bus.d_we) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
                g.is_f = bus.if_gnt;
                g.c = cyc;
                glog.push_back(g);
            end else begin
                chk("mem_en_idle", bus.mem_en, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_gnt(input bit want_f, input string name, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (want_f ? bus.if_gnt : bus.d_gnt) begin
                c = cyc;
                break;
            end
            tick();
        end
        chk({name, "_seen"}, c >= 0, 1);
    endtask

    typedef struct {bit if_req; bit d_req; bit d_we; bit halt; bit e_if; bit e_d; bit e_we;} vec_t;
    vec_t vt [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1;
        string pat;
        vt[0] = '{1, 0, 0, 0, 1, 0, 0};
        vt[1] = '{0, 1, 0, 0, 0, 1, 0};
        vt[2] = '{0, 1, 1, 0, 0, 1, 1};
        vt[3] = '{1, 1, 0, 0, 0, 1, 0};
        vt[4] = '{1, 0, 0, 1, 0, 0, 0};
        vt[5] = '{1, 1, 1, 1, 0, 1, 1};
        vt[6] = '{0, 0, 0, 0, 0, 0, 0};
        bus.halt = 0; bus.flush = 0; bus.if_addr = '0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_byt_typ = '0;
        rst = 1;
        bus.if_req = 1;
        bus.d_req = 1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        bus.if_req = 0;
        bus.d_req = 0;
        rst = 0;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            bus.if_addr = 16'h0100 + 16'(i);
            bus.d_addr = 16'h0800 + 16'(i);
            bus.d_wdata = 32'h1234_0000 + 32'(i);
            bus.d_byt_typ = 3'(i);
            bus.if_req = vt[i].if_req;
            bus.d_req = vt[i].d_req;
            bus.d_we = vt[i].d_we;
            bus.halt = vt[i].halt;
            #1;
            chk($sformatf("vec%0d_if_gnt", i), bus.if_gnt, vt[i].e_if);
            chk($sformatf("vec%0d_d_gnt", i), bus.d_gnt, vt[i].e_d);
            chk($sformatf("vec%0d_mem_we", i), bus.mem_we, vt[i].e_we);
            chk($sformatf("vec%0d_byt_typ", i), bus.mem_byt_typ, vt[i].e_d ? 3'(i) : 3'd0);
            tick();
            bus.if_req = 0; bus.d_req = 0; bus.d_we = 0; bus.halt = 0;
            idle(L + 3);
        end

        bus.if_addr = 16'h0200; bus.d_addr = 16'h0900;
        bus.if_req = 1; bus.d_req = 1;
        #1;
        chk("both_d_first", bus.d_gnt, 1);
        chk("both_no_if", bus.if_gnt, 0);
        t0 = cyc;
        tick();
        bus.d_req = 0;
        wait_gnt(1, "both_if", t1);
        chk("both_if_gap", t1 - t0, L + 1);
        tick();
        bus.if_req = 0;
        idle(L + 3);

        glog.delete();
        bus.if_req = 1; bus.d_req = 1;
        for (int i = 0; i < 200 && glog.size() < 10; i++) tick();
        bus.if_req = 0; bus.d_req = 0;
        chk("streak_count", glog.size() >= 10, 1);
        pat = "DDDDFDDDDF";
        for (int i = 0; i < 10 && i < glog.size(); i++) begin
            chk($sformatf("streak_order%0d", i), glog[i].is_f, pat[i] == "F");
            if (i > 0) chk($sformatf("streak_gap%0d", i), glog[i].c - glog[i-1].c, L + 1);
        end
        idle(L + 3);

        bus.if_addr = 16'h0300; bus.if_req = 1;
        #1; chk("fl_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0; bus.flush = 1;
        tick(); bus.flush = 0;
        idle(L + 3);
        bus.if_addr = 16'h0301; bus.if_req = 1;
        #1; chk("fl_next_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0;
        idle(L + 3);
        bus.if_addr = 16'h0302; bus.if_req = 1; bus.flush = 1;
        #1; chk("fl_gcyc_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0; bus.flush = 0;
        idle(L + 3);
        bus.d_addr = 16'h0A00; bus.d_we = 0; bus.d_req = 1;
        #1; chk("fl_data_gnt", bus.d_gnt, 1);
        tick(); bus.d_req = 0; bus.flush = 1;
        tick(); bus.flush = 0;
        idle(L + 3);
        bus.if_addr = 16'h0303; bus.if_req = 1;
        #1; chk("fl_resp_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0;
        idle(L);
        bus.flush = 1;
        tick(); bus.flush = 0;
        idle(L + 3);

        glog.delete();
        bus.halt = 1; bus.if_addr = 16'h0400; bus.if_req = 1;
        bus.d_addr = 16'h0B00; bus.d_we = 1; bus.d_wdata = 32'hDEADBEEF; bus.d_byt_typ = 3'b010; bus.d_req = 1;
        #1;
        chk("halt_d_gnt", bus.d_gnt, 1);
        chk("halt_if_gnt", bus.if_gnt, 0);
        chk("halt_mem_we", bus.mem_we, 1);
        chk("halt_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick(); bus.d_req = 0; bus.d_we = 0;
        idle(8);
        chk("halt_grants", glog.size(), 1);
        bus.if_req = 0; bus.halt = 0;
        idle(2);
        bus.if_addr = 16'h0401; bus.if_req = 1;
        #1; chk("halt_late_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0; bus.halt = 1;
        idle(L + 3);
        bus.halt = 0;

        bus.if_addr = 16'h0500; bus.if_req = 1;
        #1; chk("rw_gnt", bus.if_gnt, 1);
        tick(); bus.if_req = 0;
        #1; rst = 1; bus.d_req = 1; bus.if_req = 1;
        #1;
        chk("rw_if_gnt", bus.if_gnt, 0);
        chk("rw_d_gnt", bus.d_gnt, 0);
        chk("rw_mem_en", bus.mem_en, 0);
        chk("rw_if_rvalid", bus.if_rvalid, 0);
        chk("rw_d_rvalid", bus.d_rvalid, 0);
        chk("rw_if_rdata", bus.if_rdata, 0);
        chk("rw_d_rdata", bus.d_rdata, 0);
        tick(); bus.d_req = 0; bus.if_req = 0;
        tick(); rst = 0;
        idle(L + 4);
        bus.d_addr = 16'h0C00; bus.d_we = 0; bus.d_req = 1;
        #1; chk("rw_after_gnt", bus.d_gnt, 1);
        tick(); bus.d_req = 0;
        idle(L + 3);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
